// File: rtl/qtree_run_sequencer.sv
// Run-level sequencer: collects NUM_ARGS root pointers, fires Go plus every argument token once,
// then forwards the kernel result to the host. Optional WAIT watchdog: define QTREE_SEQ_TIMEOUT_EN.
module qtree_run_sequencer #(
  parameter int unsigned NUM_ARGS = 3,
  parameter int unsigned PTR_W    = 16,
  parameter int unsigned TMO_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      root_valid,
  input  logic [PTR_W-1:0]          root_data,
  output logic                      root_ready,
  output logic                      go_d,
  input  logic                      go_r,
  output logic [NUM_ARGS*PTR_W-1:0] arg_d,
  input  logic [NUM_ARGS-1:0]       arg_r,
  input  logic [PTR_W-1:0]          res_d,
  output logic                      res_r,
  output logic                      out_valid,
  output logic [PTR_W-1:0]          out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [7:0]                run_count,
  output logic                      err
);

  localparam int unsigned IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ARGS - 1);

  if (NUM_ARGS < 1 || NUM_ARGS > 8 || PTR_W < 2 || TMO_W < 1) begin : g_param_chk
    $error("qtree_run_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t               state_q, state_nx;
  logic [IDX_W-1:0]     idx_q, idx_nx;
  logic [NUM_ARGS-1:0]  arg_vld_q, arg_vld_nx;
  logic [PTR_W-1:0]     slot_q [NUM_ARGS];
  logic                 load_en;
  logic                 root_ready_nx, go_nx, res_r_nx, out_valid_nx, busy_nx, err_nx;
  logic [PTR_W-1:0]     out_data_nx;
  logic [7:0]           run_count_nx;
`ifdef QTREE_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0]     tmo_q, tmo_nx;
`endif

  // Argument tokens carry the stored root pointer with bit 0 replaced by the token valid.
  always_comb begin
    arg_d = '0;
    for (int i = 0; i < int'(NUM_ARGS); i++) begin
      arg_d[i*PTR_W +: PTR_W] = {slot_q[i][PTR_W-1:1], arg_vld_q[i]};
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_nx      = state_q;
    idx_nx        = idx_q;
    arg_vld_nx    = arg_vld_q;
    root_ready_nx = root_ready;
    go_nx         = go_d;
    res_r_nx      = res_r;
    out_valid_nx  = out_valid;
    out_data_nx   = out_data;
    run_count_nx  = run_count;
    err_nx        = 1'b0;
    load_en       = 1'b0;
`ifdef QTREE_SEQ_TIMEOUT_EN
    tmo_nx        = (state_q == S_WAIT) ? tmo_q + TMO_W'(1) : '0;
`endif
    unique case (state_q)
      S_LOAD: begin
        root_ready_nx = 1'b1;
        if (root_valid && root_ready) begin
          load_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            root_ready_nx = 1'b0;
            idx_nx        = '0;
            go_nx         = 1'b1;
            arg_vld_nx    = '1;
            state_nx      = S_ISSUE;
          end else begin
            idx_nx = idx_q + IDX_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (go_d && go_r) go_nx = 1'b0;
        arg_vld_nx = arg_vld_q & ~arg_r;
        if (!go_nx && arg_vld_nx == '0) begin
          res_r_nx = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (res_r && res_d[0]) begin
          out_data_nx  = res_d;
          out_valid_nx = 1'b1;
          res_r_nx     = 1'b0;
          state_nx     = S_DRAIN;
        end
`ifdef QTREE_SEQ_TIMEOUT_EN
        else if (tmo_nx == '1) begin
          err_nx        = 1'b1;
          out_data_nx   = '0;
          out_valid_nx  = 1'b0;
          res_r_nx      = 1'b0;
          idx_nx        = '0;
          root_ready_nx = 1'b1;
          state_nx      = S_LOAD;
        end
`endif
      end
      S_DRAIN: begin
        if (out_ready) begin
          run_count_nx  = run_count + 8'd1;
          out_valid_nx  = 1'b0;
          idx_nx        = '0;
          root_ready_nx = 1'b1;
          state_nx      = S_LOAD;
        end
      end
    endcase
    busy_nx = (state_nx != S_LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      arg_vld_q  <= '0;
      root_ready <= 1'b0;
      go_d       <= 1'b0;
      res_r      <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      run_count  <= 8'd0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_nx;
      idx_q      <= idx_nx;
      arg_vld_q  <= arg_vld_nx;
      root_ready <= root_ready_nx;
      go_d       <= go_nx;
      res_r      <= res_r_nx;
      out_valid  <= out_valid_nx;
      out_data   <= out_data_nx;
      run_count  <= run_count_nx;
      busy       <= busy_nx;
      err        <= err_nx;
    end
  end

  // Root pointer capture slots, one per kernel argument.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_ARGS); i++) slot_q[i] <= '0;
    end else if (load_en) begin
      slot_q[idx_q] <= root_data;
    end
  end

`ifdef QTREE_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_nx;
  end
`endif

endmodule

// File: tb/tb_qtree_run_sequencer.sv
// Directed self-checking bench for qtree_run_sequencer (NUM_ARGS=3, PTR_W=16, TMO_W=4).
module tb_qtree_run_sequencer;
  localparam int unsigned NUM_ARGS = 3;
  localparam int unsigned PTR_W    = 16;
  localparam int unsigned TMO_W    = 4;
  localparam int unsigned AW       = NUM_ARGS * PTR_W;

  logic                clk = 1'b0;
  logic                reset;
  logic                root_valid;
  logic [PTR_W-1:0]    root_data;
  logic                root_ready;
  logic                go_d;
  logic                go_r;
  logic [AW-1:0]       arg_d;
  logic [NUM_ARGS-1:0] arg_r;
  logic [PTR_W-1:0]    res_d;
  logic                res_r;
  logic                out_valid;
  logic [PTR_W-1:0]    out_data;
  logic                out_ready;
  logic                busy;
  logic [7:0]          run_count;
  logic                err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qtree_run_sequencer #(.NUM_ARGS(NUM_ARGS), .PTR_W(PTR_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .reset(reset),
    .root_valid(root_valid), .root_data(root_data), .root_ready(root_ready),
    .go_d(go_d), .go_r(go_r), .arg_d(arg_d), .arg_r(arg_r),
    .res_d(res_d), .res_r(res_r),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .run_count(run_count), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PTR_W-1:0] root_val(input int a);
    return PTR_W'((a << 4) | 1);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_root_ready"}, 64'(root_ready), 64'(0));
    check({tag, "_go_d"},       64'(go_d),       64'(0));
    check({tag, "_arg_d"},      64'(arg_d),      64'(0));
    check({tag, "_res_r"},      64'(res_r),      64'(0));
    check({tag, "_out_valid"},  64'(out_valid),  64'(0));
    check({tag, "_out_data"},   64'(out_data),   64'(0));
    check({tag, "_run_count"},  64'(run_count),  64'(0));
    check({tag, "_err"},        64'(err),        64'(0));
    check({tag, "_busy"},       64'(busy),       64'(0));
  endtask

  // Present one root pointer and wait (bounded) for it to be taken.
  task automatic push_root(input logic [PTR_W-1:0] v);
    bit took;
    took       = 1'b0;
    root_valid = 1'b1;
    root_data  = v;
    for (int c = 0; c < 10 && !took; c++) begin
      took = root_ready;
      tick();
    end
    root_valid = 1'b0;
    check("push_root_taken", 64'(took), 64'(1));
  endtask

  task automatic run_once(input logic [PTR_W-1:0] a, input logic [PTR_W-1:0] b,
                          input logic [PTR_W-1:0] c, input logic [PTR_W-1:0] res);
    push_root(a);
    push_root(b);
    push_root(c);
    check("run_go", 64'(go_d), 64'(1));
    check("run_args", 64'(arg_d), 64'({c, b, a}));
    go_r = 1'b1; arg_r = '1; res_d = res; out_ready = 1'b0;
    tick();
    check("run_wait_res_r", 64'(res_r), 64'(1));
    tick();
    check("run_out_valid", 64'(out_valid), 64'(1));
    check("run_out_data", 64'(out_data), 64'(res));
    out_ready = 1'b1;
    tick();
    check("run_drained", 64'(out_valid), 64'(0));
    go_r = 1'b0; arg_r = '0; res_d = '0; out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  int            acc;
  int            base;
  int            edges;
  int            n;
  int            exp_rc;
  bit            done;
  bit            rr;
  bit            ov;
  logic [AW-1:0] exp_args;

  initial begin
    reset = 1'b1; root_valid = 1'b0; root_data = '0; go_r = 1'b0;
    arg_r = '0; res_d = '0; out_ready = 1'b0;
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();
    check("post_rst_root_ready", 64'(root_ready), 64'(1));

    // Load three roots; a valid result seen outside WAIT must be ignored.
    res_d = 16'h00AB;
    push_root(16'h0011);
    push_root(16'h0021);
    push_root(16'h0031);
    check("t1_root_ready", 64'(root_ready), 64'(0));
    check("t1_go_d", 64'(go_d), 64'(1));
    check("t1_arg_d", 64'(arg_d), 64'(48'h0031_0021_0011));
    check("t1_busy", 64'(busy), 64'(1));
    tick();
    check("t1_hold_arg_d", 64'(arg_d), 64'(48'h0031_0021_0011));
    check("t1_hold_go_d", 64'(go_d), 64'(1));
    check("t1_res_ignored", 64'(out_valid), 64'(0));

    // Staggered token handshakes.
    go_r = 1'b1; arg_r = 3'b001;
    tick();
    check("t2_go_dropped", 64'(go_d), 64'(0));
    check("t2_arg0", 64'(arg_d), 64'(48'h0031_0021_0010));
    check("t2_res_r0", 64'(res_r), 64'(0));
    arg_r = 3'b100;
    tick();
    check("t2_arg2", 64'(arg_d), 64'(48'h0030_0021_0010));
    check("t2_res_r1", 64'(res_r), 64'(0));
    arg_r = 3'b010; res_d = '0;
    tick();
    check("t2_arg1", 64'(arg_d), 64'(48'h0030_0020_0010));
    check("t2_wait_res_r", 64'(res_r), 64'(1));
    go_r = 1'b0; arg_r = '0;

    // Result capture with host back-pressure.
    res_d = 16'h0045; out_ready = 1'b0;
    tick();
    check("t3_out_valid", 64'(out_valid), 64'(1));
    check("t3_out_data", 64'(out_data), 64'(16'h0045));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", 64'(out_valid), 64'(1));
      check("t3_hold_data", 64'(out_data), 64'(16'h0045));
      check("t3_hold_res_r", 64'(res_r), 64'(0));
      check("t3_hold_count", 64'(run_count), 64'(0));
    end
    out_ready = 1'b1; res_d = '0;
    tick();
    check("t3_drained", 64'(out_valid), 64'(0));
    check("t3_run_count", 64'(run_count), 64'(1));
    check("t3_root_ready", 64'(root_ready), 64'(1));
    check("t3_busy", 64'(busy), 64'(0));

    // 255 more back-to-back runs, root_valid held high throughout.
    go_r = 1'b1; arg_r = '1; out_ready = 1'b1;
    acc = 0; root_data = root_val(0); root_valid = 1'b1;
    for (int r = 0; r < 255; r++) begin
      base  = acc;
      done  = 1'b0;
      edges = 0;
      res_d = PTR_W'((r << 1) | 1);
      exp_args = {root_val(base + 2), root_val(base + 1), root_val(base)};
      while (!done && edges < 20) begin
        rr = root_ready;
        ov = out_valid;
        tick();
        edges++;
        if (rr) begin
          acc++;
          root_data = root_val(acc);
        end
        if (ov) done = 1'b1;
        else if (go_d) check("t4_args", 64'(arg_d), 64'(exp_args));
        else if (out_valid) check("t4_res", 64'(out_data), 64'(res_d));
      end
      check("t4_run_len", 64'(edges), 64'(6));
    end
    root_valid = 1'b0;
    check("t4_wrap", 64'(run_count), 64'(0));
    check("t4_roots_taken", 64'(acc), 64'(765));
    exp_rc = 0;
    go_r = 1'b0; arg_r = '0; res_d = '0; out_ready = 1'b0;

    // No result: watchdog expiry, or indefinite WAIT without it.
    push_root(16'h0101);
    push_root(16'h0201);
    push_root(16'h0301);
    go_r = 1'b1; arg_r = '1;
    tick();
    go_r = 1'b0; arg_r = '0;
    check("t6_in_wait", 64'(res_r), 64'(1));
`ifdef QTREE_SEQ_TIMEOUT_EN
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    check("t6_tmo_cycles", 64'(n), 64'(15));
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_out_data", 64'(out_data), 64'(0));
    check("t6_run_count", 64'(run_count), 64'(exp_rc));
    check("t6_busy", 64'(busy), 64'(0));
    tick();
    check("t6_err_pulse", 64'(err), 64'(0));
    check("t6_root_ready", 64'(root_ready), 64'(1));
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t6_no_err", 64'(err), 64'(0));
    end
    check("t6_still_wait", 64'(res_r), 64'(1));
    check("t6_busy", 64'(busy), 64'(1));
    res_d = 16'h0077;
    tick();
    check("t6_late_res", 64'(out_data), 64'(16'h0077));
    res_d = '0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_rc = exp_rc + 1;
    check("t6_run_count", 64'(run_count), 64'(exp_rc));
`endif

    // Reset mid-ISSUE after two tokens completed, then a clean run.
    run_once(16'h0A01, 16'h0B01, 16'h0C01, 16'h00C5);
    exp_rc = exp_rc + 1;
    check("t5_pre_count", 64'(run_count), 64'(exp_rc));
    push_root(16'h0D01);
    push_root(16'h0E01);
    push_root(16'h0F01);
    go_r = 1'b1; arg_r = 3'b001;
    tick();
    check("t5_two_done", 64'(arg_d), 64'(48'h0F01_0E01_0D00));
    check("t5_go_done", 64'(go_d), 64'(0));
    go_r = 1'b0; arg_r = '0;
    #3 reset = 1'b1;
    #1 check_reset_vals("t5_async");
    tick();
    reset = 1'b0;
    tick();
    check("t5_root_ready", 64'(root_ready), 64'(1));
    run_once(16'h1101, 16'h1201, 16'h1301, 16'h0013);
    check("t5_run_count", 64'(run_count), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
